// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs operand fields and immediates into machine words,
// expands the LI pseudo-op into ADDI or LUI(+ADDI), and marks illegal requests with NOP_WORD.
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD2 = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic        out_valid_r, out_err_r, out_last_r;
  logic [31:0] out_instr_r, word2_r;
  logic [31:0] enc_word_s, enc_word2_s;
  logic        enc_err_s, enc_last_s, enc_two_s;
  logic [19:0] li_hi_s;
  logic        in_ready_s, accept_s, out_hs_s;

  function automatic logic fits12(input logic [31:0] imm);
    return imm[31:11] == {21{imm[11]}};
  endfunction

  function automatic logic fits13(input logic [31:0] imm);
    return imm[31:12] == {20{imm[12]}};
  endfunction

  function automatic logic fits21(input logic [31:0] imm);
    return imm[31:20] == {12{imm[20]}};
  endfunction

  // Upper part is rounded up when the low 12 bits will be sign-extended negative by ADDI.
  assign li_hi_s    = in_imm[31:12] + {19'd0, in_imm[11]};
  assign in_ready_s = rst_n && (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign out_hs_s   = out_valid_r && out_ready;

  // Encode the presented request into up to two words plus error/last flags.
  always_comb begin
    enc_word_s  = NOP_WORD;
    enc_word2_s = 32'h0000_0000;
    enc_err_s   = 1'b1;
    enc_last_s  = 1'b1;
    enc_two_s   = 1'b0;
    case (in_fmt)
      3'd0: begin
        enc_word_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err_s  = 1'b0;
      end
      3'd1: begin
        if (fits12(in_imm)) begin
          enc_word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err_s  = 1'b0;
        end else begin
          enc_err_s  = 1'b1;
        end
      end
      3'd2: begin
        if (fits12(in_imm)) begin
          enc_word_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
          enc_err_s  = 1'b0;
        end else begin
          enc_err_s  = 1'b1;
        end
      end
      3'd3: begin
        if (fits13(in_imm) && !in_imm[0]) begin
          enc_word_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
          enc_err_s  = 1'b0;
        end else begin
          enc_err_s  = 1'b1;
        end
      end
      3'd4: begin
        if (in_imm[11:0] == 12'd0) begin
          enc_word_s = {in_imm[31:12], in_rd, in_opcode};
          enc_err_s  = 1'b0;
        end else begin
          enc_err_s  = 1'b1;
        end
      end
      3'd5: begin
        if (fits21(in_imm) && !in_imm[0]) begin
          enc_word_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
          enc_err_s  = 1'b0;
        end else begin
          enc_err_s  = 1'b1;
        end
      end
      3'd6: begin
        enc_err_s = 1'b0;
        if (fits12(in_imm)) begin
          enc_word_s = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'b0010011};
        end else begin
          enc_word_s = {li_hi_s, in_rd, 7'b0110111};
          if (in_imm[11:0] != 12'd0) begin
            enc_two_s   = 1'b1;
            enc_last_s  = 1'b0;
            enc_word2_s = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'b0010011};
          end else begin
            enc_two_s   = 1'b0;
          end
        end
      end
      default: begin
        enc_word_s = NOP_WORD;
        enc_err_s  = 1'b1;
      end
    endcase
  end

  // Next-state logic: HOLD2 covers the window where the LUI word waits for its handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && enc_two_s) begin
          state_next_s = HOLD2;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD2: begin
        if (out_hs_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD2;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output register and buffered second LI word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_instr_r <= 32'h0000_0000;
      out_err_r   <= 1'b0;
      out_last_r  <= 1'b0;
      word2_r     <= 32'h0000_0000;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_instr_r <= enc_word_s;
      out_err_r   <= enc_err_s;
      out_last_r  <= enc_last_s;
      if (enc_two_s) begin
        word2_r <= enc_word2_s;
      end
    end else if (out_hs_s) begin
      if (state_r == HOLD2) begin
        out_instr_r <= word2_r;
        out_err_r   <= 1'b0;
        out_last_r  <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_instr = out_instr_r;
  assign out_err   = out_err_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder; random traffic is scored against
// a reference model that works from signed immediate ranges and LI arithmetic.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err, out_last;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] w;
    logic        e;
    logic        l;
  } exp_t;
  exp_t sbq[$];

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic e, input logic l);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, w);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e});
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
  endtask

  // One-word request with out_ready high: accepted at the next edge, checked right after it.
  task automatic single(input string tag, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] w, input logic e);
    drive(f, op, rd, r1, r2, f3, 7'd0, imm);
    step();
    in_valid = 1'b0;
    chk_word(tag, w, e, 1'b1);
  endtask

  // Reference model: legality from signed ranges, LI from value = hi*4096 + sext(lo).
  task automatic model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    int    v;
    int    lo;
    int    hi;
    logic [31:0] hv;
    exp_t  nop;
    v   = $signed(imm);
    nop = '{32'h0000_0013, 1'b1, 1'b1};
    case (f)
      3'd0: sbq.push_back('{{f7, r2, r1, f3, rd, op}, 1'b0, 1'b1});
      3'd1: if (v >= -2048 && v <= 2047) sbq.push_back('{{imm[11:0], r1, f3, rd, op}, 1'b0, 1'b1});
            else sbq.push_back(nop);
      3'd2: if (v >= -2048 && v <= 2047)
              sbq.push_back('{{imm[11:5], r2, r1, f3, imm[4:0], op}, 1'b0, 1'b1});
            else sbq.push_back(nop);
      3'd3: if (v >= -4096 && v <= 4095 && (v % 2) == 0)
              sbq.push_back('{{imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], op}, 1'b0, 1'b1});
            else sbq.push_back(nop);
      3'd4: if ((imm % 4096) == 0) sbq.push_back('{{imm[31:12], rd, op}, 1'b0, 1'b1});
            else sbq.push_back(nop);
      3'd5: if (v >= -1048576 && v <= 1048575 && (v % 2) == 0)
              sbq.push_back('{{imm[20], imm[10:1], imm[11], imm[19:12], rd, op}, 1'b0, 1'b1});
            else sbq.push_back(nop);
      3'd6: begin
        if (v >= -2048 && v <= 2047) begin
          sbq.push_back('{{imm[11:0], 5'd0, 3'd0, rd, 7'h13}, 1'b0, 1'b1});
        end else begin
          lo = $signed({{20{imm[11]}}, imm[11:0]});
          hi = (v - lo) >>> 12;
          hv = hi;
          sbq.push_back('{{hv[19:0], rd, 7'h37}, 1'b0, lo == 0});
          if (lo != 0) sbq.push_back('{{imm[11:0], rd, 3'd0, rd, 7'h13}, 1'b0, 1'b1});
        end
      end
      default: sbq.push_back(nop);
    endcase
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    logic [31:0] edges [6];
    r = $urandom;
    edges = '{32'h0000_0800, 32'h0000_07FF, 32'hFFFF_F800, 32'h7FFF_F800,
              32'h8000_0000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 5))
      0: return {{20{r[11]}}, r[11:0]};
      1: return {{19{r[12]}}, r[12:1], 1'b0};
      2: return {{11{r[20]}}, r[20:1], 1'b0};
      3: return {r[31:12], 12'd0};
      4: return r;
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] held_w;
    logic        held;
    int          guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    single("i_neg1", 3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_8293, 1'b0);
    single("b_8", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8, 32'h0020_8463, 1'b0);
    single("j_800", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 32'h0010_00EF, 1'b0);
    single("li_lui_only", 3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_5537, 1'b0);
    single("err_j_odd", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0000_0013, 1'b1);
    single("err_i_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0000_0013, 1'b1);
    single("err_fmt7", 3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0013, 1'b1);
    single("after_err", 3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_8293, 1'b0);
    step();

    // Two-word LI under backpressure.
    out_ready = 1'b0;
    drive(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    step();
    in_valid = 1'b0;
    chk_word("li_w1", 32'h1234_6537, 1'b0, 1'b0);
    chk("li_hold_rdy0", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_word("li_w1_hold", 32'h1234_6537, 1'b0, 1'b0);
      chk("li_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("hold2_rdy", {31'd0, in_ready}, 32'd0);
    step();
    chk_word("li_w2", 32'hFFF5_0513, 1'b0, 1'b1);
    step();
    chk("li_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back single-word requests with no bubble.
    for (int k = 1; k <= 3; k++) begin
      drive(3'd1, 7'h13, k[4:0], 5'd0, 5'd0, 3'd0, 7'd0, k);
      #1 chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
      step();
      chk_word("b2b", {k[11:0], 5'd0, 3'd0, k[4:0], 7'h13}, 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Reset in HOLD2 drops the pending ADDI.
    out_ready = 1'b0;
    drive(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    step();
    in_valid = 1'b0;
    chk_word("rst2_w1", 32'h1234_6537, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("rst2_no_addi", {31'd0, out_valid}, 32'd0);
    single("post_rst", 3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_8293, 1'b0);
    step();

    // Random traffic against the reference model.
    held = 1'b0; held_w = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      if (i < 1400 && $urandom_range(0, 3) != 0) begin
        drive($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, rand_imm());
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (i >= 1400) || ($urandom_range(0, 3) != 0);
      #1;
      if (held) chk("rnd_stable", out_instr, held_w);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("rnd_spurious", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rnd_instr", out_instr, e.w);
          chk("rnd_err", {31'd0, out_err}, {31'd0, e.e});
          chk("rnd_last", {31'd0, out_last}, {31'd0, e.l});
        end
      end
      held   = out_valid && !out_ready;
      held_w = out_instr;
      if (in_valid && in_ready) model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                      in_funct3, in_funct7, in_imm);
      step();
    end
    guard = 0;
    while (out_valid && guard < 10) begin
      step();
      guard++;
    end
    chk("rnd_queue_empty", sbq.size(), 32'd0);
    chk("rnd_out_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder. It packs operand fields and a 32-bit immediate into machine words, applying the same bit scattering the decode-side immediate generator undoes. It also expands a load-immediate (LI) pseudo-op into a LUI/ADDI sequence. It sits between the workshop's program-builder/boot-loader path and instruction memory, and uses valid/ready handshakes on both sides.

Parameters:
NOP_WORD, 32'h0000_0013, word emitted on an encoding error (ADDI x0,x0,0)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted on in_valid && in_ready
in_fmt  input  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LI, 7 reserved
in_opcode  input  7  opcode field; ignored for LI
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field
in_funct7  input  7  funct7 field; R only
in_imm  input  32  byte-offset / value immediate, two's complement
out_valid  output  1  output word valid
out_ready  input  1  word consumed on out_valid && out_ready
out_instr  output  32  encoded instruction
out_err  output  1  word is NOP_WORD because the request was illegal
out_last  output  1  final word of the current request

Behaviour:
- Reset: clk and rst_n only; a synchronous active-low reset, sampled on the clk edge.
- Reset state: FSM in IDLE; out_valid=0, out_instr=0, out_err=0, out_last=0.
- in_ready is 0 while rst_n=0.
- Reset mid-sequence discards any pending second LI word.
- FSM states:
  - IDLE: output register empty or draining.
  - HOLD2: first LI word presented; second word buffered internally.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Single-word requests therefore sustain 1 word per cycle.
- Latency: a request accepted at edge N shows out_valid from edge N (registered output), i.e. 1 cycle after in_valid is sampled.
- Stability: while out_valid && !out_ready, out_instr, out_err and out_last hold stable.
- Encodings, with {} meaning concatenation MSB first:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. Legal iff imm[31:11] are all equal.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Same legality as I.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Legal iff imm[31:12] are all equal and imm[0]=0.
  - U: {imm[31:12], rd, opcode}. Legal iff imm[11:0]=0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Legal iff imm[31:20] are all equal and imm[0]=0.
  - fmt 7: always illegal.
- LI expansion (in_opcode, funct3, funct7 and rs fields ignored):
  - imm fits signed 12 bits: one word, ADDI rd,x0,imm[11:0]; out_last=1.
  - Otherwise hi = imm[31:12] + imm[11] (20-bit, wraps modulo 2^20).
    - Word 1: LUI rd,hi = {hi, rd, 7'b0110111}.
    - If imm[11:0] != 0: word 2 is ADDI rd,rd,imm[11:0] = {imm[11:0], rd, 3'b000, rd, 7'b0010011}. Word 1 has out_last=0, word 2 has out_last=1.
    - If imm[11:0] == 0: only the LUI word is emitted, with out_last=1.
- Illegal request: exactly one word, out_instr=NOP_WORD, out_err=1, out_last=1. No exception or stall beyond the normal handshake.
- HOLD2 transitions:
  - Entered when a two-word LI is accepted.
  - On the handshake of word 1, the output register loads word 2 and the FSM returns to IDLE.
  - in_ready stays 0 throughout HOLD2.
- Simultaneous events:
  - Output handshake and new request accepted in the same cycle: the output register loads the new word with no bubble.
  - HOLD2 with out_ready=1: word 2 appears on the next cycle.
- Register index 0 is encoded as given, with no special casing except the LI ADDI form described above.

Test Plan:
- fmt=I, opcode=0x13, rd=5, rs1=1, funct3=0, imm=-1 -> out_instr=0xFFF08293, err=0, last=1, one cycle after accept.
- fmt=B, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463. fmt=J, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- fmt=LI, rd=10, imm=0x12345FFF -> words 0x12346537 (last=0) then 0xFFF50513 (last=1). Same rd with imm=0x12345000 -> single word 0x12345537, last=1.
- Errors: fmt=J with imm=3, fmt=I with imm=2048, and fmt=7 -> each gives 0x00000013, err=1, last=1. A following legal request encodes correctly.
- Backpressure: hold out_ready=0 for 3 cycles during the two-word LI -> word 1 stays stable and in_ready=0. Release -> word 2 next cycle. Back-to-back I requests with out_ready=1 -> one word per cycle, no bubbles.
- Reset: assert rst_n=0 in HOLD2 -> next edge out_valid=0, pending ADDI is never emitted. First request after reset encodes normally.
